mc_controller: RTL and testbench

Multicycle MIPS main control unit. It is the initiator side of the ALU-control interface: it decodes the instruction opcode and sequences the datapath through fetch, decode and execute states. It drives `aluop` into the ALU-control decoder and consumes that ALU's `zero` flag for branches. It sits between the instruction register and the shared-memory multicycle datapath.

---
 rtl/mc_controller.sv | 169 ++++++++++++++++
 tb/tb_mc_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS main control FSM (fetch/decode/execute sequencing).
// Rev 1.0
`default_nettype none

module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [1:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet still Moore.
  always_comb begin
    ctrl_d = decode(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= decode(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign aluop    = ctrl_q.aluop;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign iord     = ctrl_q.iord;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign state    = state_q;

  // Strobes are masked by reset so an abort takes effect without a clock edge.
  assign irwrite  = ctrl_q.irwrite  & ~reset;
  assign memwrite = ctrl_q.memwrite & ~reset;
  assign regwrite = ctrl_q.regwrite & ~reset;
  assign pcen     = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & zero));

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for the multicycle main control FSM.
`default_nettype none

module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic [1:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       pcen;
  logic [3:0] state;

  mc_controller dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .aluop    (aluop),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .iord     (iord),
    .irwrite  (irwrite),
    .memwrite (memwrite),
    .regwrite (regwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .pcen     (pcen),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {state, aluop, alusrca, alusrcb, pcsrc, iord, irwrite,
                memwrite, regwrite, regdst, memtoreg, pcen};

  typedef struct packed {
    logic [17:0] exp;
    logic        z;
  } entry_t;

  entry_t sb[$];
  int     checks = 0;
  int     errors = 0;

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  // Expected output vector for a state, straight from the output table.
  function automatic logic [17:0] model(input logic [3:0] s, input logic z, input logic rst);
    logic [1:0] e_aluop, e_srcb, e_pcsrc;
    logic e_srca, e_iord, e_irw, e_mw, e_rw, e_rd, e_m2r, e_pcen;
    e_aluop = 2'b00; e_srcb = 2'b00; e_pcsrc = 2'b00;
    e_srca = 0; e_iord = 0; e_irw = 0; e_mw = 0; e_rw = 0; e_rd = 0; e_m2r = 0; e_pcen = 0;
    case (s)
      4'd0:  begin e_srcb = 2'b01; e_irw = 1; e_pcen = 1; end
      4'd1:  e_srcb = 2'b11;
      4'd2:  begin e_srca = 1; e_srcb = 2'b10; end
      4'd3:  e_iord = 1;
      4'd4:  begin e_m2r = 1; e_rw = 1; end
      4'd5:  begin e_iord = 1; e_mw = 1; end
      4'd6:  begin e_srca = 1; e_aluop = 2'b10; end
      4'd7:  begin e_rd = 1; e_rw = 1; end
      4'd8:  begin e_srca = 1; e_aluop = 2'b01; e_pcsrc = 2'b01; e_pcen = z; end
      4'd9:  begin e_srca = 1; e_srcb = 2'b10; end
      4'd10: e_rw = 1;
      4'd11: begin e_pcsrc = 2'b10; e_pcen = 1; end
      default: ;
    endcase
    if (rst) begin
      e_irw = 0; e_mw = 0; e_rw = 0; e_pcen = 0;
    end
    return {s, e_aluop, e_srca, e_srcb, e_pcsrc, e_iord, e_irw, e_mw, e_rw, e_rd, e_m2r, e_pcen};
  endfunction

  // Push the expected per-cycle trace of one instruction, then drive it and compare.
  task automatic run_instr(input logic [5:0] opc, input logic z_exec, input logic z_other);
    logic [3:0] seq[$];
    entry_t     e;
    int         n;
    seq = {4'd0, 4'd1};
    case (opc)
      6'b100011: begin seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd4); end
      6'b101011: begin seq.push_back(4'd2); seq.push_back(4'd5); end
      6'b000000: begin seq.push_back(4'd6); seq.push_back(4'd7); end
      6'b000100: seq.push_back(4'd8);
      6'b001000: begin seq.push_back(4'd9); seq.push_back(4'd10); end
      6'b000010: seq.push_back(4'd11);
      default: ;
    endcase
    n = seq.size();
    foreach (seq[k]) begin
      e.z   = (seq[k] == 4'd8) ? z_exec : z_other;
      e.exp = model(seq[k], e.z, 1'b0);
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      e = sb.pop_front();
      @(negedge clk);
      if (i == 0) op = opc;
      zero = e.z;
      #1;
      check_eq($sformatf("op%b_cyc%0d", opc, i), obs, e.exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    zero  = 1'b0;
    op    = 6'b111111;
    #3;
    check_eq("reset_init", obs, model(4'd0, 1'b0, 1'b1));
    @(posedge clk);
    #2 reset = 1'b0;

    run_instr(6'b100011, 1'b0, 1'b0);   // lw
    run_instr(6'b101011, 1'b0, 1'b1);   // sw, zero high where it must not matter
    run_instr(6'b000000, 1'b0, 1'b0);   // R-type
    run_instr(6'b000100, 1'b1, 1'b0);   // beq taken
    run_instr(6'b000100, 1'b0, 1'b1);   // beq not taken, zero toggled in DECODE
    run_instr(6'b000010, 1'b0, 1'b0);   // j
    run_instr(6'b111111, 1'b0, 1'b1);   // illegal opcode
    run_instr(6'b001000, 1'b0, 1'b0);   // addi
    run_instr(6'b000010, 1'b0, 1'b0);   // j back-to-back

    // Abort an R-type mid-RTYPEWB with an asynchronous reset.
    run_instr(6'b000000, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1 check_eq("reset_async", obs, model(4'd0, 1'b0, 1'b1));
    @(posedge clk);
    #2 check_eq("reset_hold", obs, model(4'd0, 1'b0, 1'b1));
    reset = 1'b0;

    run_instr(6'b100011, 1'b0, 1'b0);   // lw after reset release
    check_eq("sb_empty", 18'(sb.size()), 18'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
